recip_sched: RTL and testbench
==============================

Name: recip_sched

Overview:
- Shares one `recip_lut` instance among N_REQ requesters (softmax row lanes). Each requester needs 1/sum for its exp-sum denominator.
- Round-robin arbitration selects one request at a time.
- The block normalizes the unsigned sum to a mantissa m in [0.5,1) and an exponent e, looks up 1/m, and returns a Q1.8 reciprocal plus a right-shift amount.
- Sits between the exp-accumulators and the normalization multipliers.

Parameters:
- N_REQ, 4, number of requesters (>=2).
- SUM_W, 16, width of each unsigned sum input (>=8).
- ID_W, $clog2(N_REQ), requester-index width (derived, localparam).
- SHIFT_W, $clog2(SUM_W+1), exponent width (derived, localparam).

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  one-hot accept strobe.
- req_sum  input  N_REQ*SUM_W  packed sums; requester i at [i*SUM_W +: SUM_W].
- resp_valid  output  1  response valid.
- resp_ready  input  1  downstream accepts response.
- resp_id  output  ID_W  index of the served requester.
- resp_recip  output  9  Q1.8 value of 1/m.
- resp_shift  output  SHIFT_W  e; 1/sum = resp_recip * 2^-(8+e).
- resp_err  output  1  sum was zero.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0, state=IDLE, rr pointer=N_REQ-1 (requester 0 wins first).
- FSM states: IDLE -> NORM -> LOOKUP -> RESP -> IDLE.
- IDLE:
  - If any req_valid, grant the first valid requester searching from pointer+1 with wrap.
  - Drive req_ready one-hot to that requester in the same cycle (combinational from req_valid and pointer). The handshake completes in that cycle.
  - Latch sum into shreg, latch id into id_q, set pointer=grant, go to NORM.
  - req_ready is all-zero in every other state.
- NORM, one step per cycle:
  - sum==0 (latched zero flag): set err, exit to LOOKUP.
  - Else if shreg[SUM_W-1]==1: exit to LOOKUP.
  - Else: shreg<<=1, lz++.
  - NORM lasts lz+1 cycles; max SUM_W.
- LOOKUP:
  - m_value = shreg[SUM_W-1 -: 7], always >=0x40.
  - Register lut_output into resp_recip, SUM_W-lz into resp_shift, id_q into resp_id, err into resp_err.
  - On err: resp_recip=0x1FF, resp_shift=0.
  - Go to RESP.
- RESP:
  - resp_valid=1; all resp_* fields stable until resp_valid && resp_ready.
  - On that handshake, go to IDLE with resp_valid=0 in the next cycle.
  - No new request is accepted in the handshake cycle.
- Latency: accept at cycle T gives resp_valid at T+lz+3. A sum with MSB set gives T+3.
- Throughput: at most one request in flight.
- Fairness: every valid requester is served within N_REQ grants.
- Requesters must hold req_valid and req_sum stable until req_ready. Deasserting earlier is allowed; such a request simply is not granted.
- rst at any cycle, including mid-NORM or in RESP: in-flight work is dropped, reset values apply next cycle, and no response is produced.

Optional Feature:
- Macro: RECIP_SCHED_FAST_NORM_EN.
- Defined:
  - NORM is replaced by a single-cycle priority encoder (leading-one detect plus barrel shift).
  - NORM always takes 1 cycle, so resp_valid arrives at T+3 for every sum, including zero.
- Undefined: serial shifter as above, with latency T+lz+3.
- Arbitration, handshakes, and result values are identical in both builds.

Test Plan (N_REQ=4, SUM_W=16):
- Single request, req0 sum=0x8000 -> req_ready[0] pulses at T. resp_valid at T+3 with recip=0x1FF, shift=16, id=0, err=0.
- req2 sum=0x0003 -> shreg normalizes to 0xC000, m=0x60. resp at T+17 (fast build: T+3) with recip=0x155, shift=2, id=2.
- req1 sum=0 -> resp_err=1, recip=0x1FF, shift=0, id=1.
- All four req_valid held high with resp_ready=1 -> grants in order 0,1,2,3,0. Exactly one req_ready bit per grant, never overlapping an in-flight op.
- resp_ready held low 5 cycles in RESP -> resp_* stable, req_ready=0 throughout. Release gives handshake, then IDLE the next cycle.
- Assert rst during NORM of sum=0x0001 -> next cycle busy=0, resp_valid=0, pointer reset. The following request from req0 is served normally.

Source files
------------

// File: rtl/recip_sched.sv
// rtl/recip_sched.sv - round-robin scheduler sharing one reciprocal LUT among softmax lanes
// RECIP_SCHED_FAST_NORM_EN selects a one-cycle leading-one normalizer instead of the serial shifter.

module recip_lut (
    input  logic [6:0] m_i,
    output logic [8:0] recip_o
);
    logic [8:0] rom [128];

    // Entry m holds round(2^15 / m), i.e. 1/(m/128) in Q1.8, saturated to 9 bits.
    // Indices below 0x40 are never addressed by a normalized mantissa.
    for (genvar g = 0; g < 128; g++) begin : g_rom
        if (g < 64) begin : g_unused
            assign rom[g] = 9'h1FF;
        end else begin : g_entry
            localparam int Q = (32768 + g / 2) / g;
            assign rom[g] = (Q > 511) ? 9'h1FF : 9'(Q);
        end
    end

    assign recip_o = rom[m_i];
endmodule

module recip_sched #(
    parameter  int N_REQ   = 4,
    parameter  int SUM_W   = 16,
    localparam int ID_W    = $clog2(N_REQ),
    localparam int SHIFT_W = $clog2(SUM_W + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*SUM_W-1:0] req_sum,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [8:0]             resp_recip,
    output logic [SHIFT_W-1:0]     resp_shift,
    output logic                   resp_err,
    output logic                   busy
);
    typedef enum logic [1:0] {S_IDLE, S_NORM, S_LOOKUP, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [SUM_W-1:0]   shreg_q, shreg_d;
    logic [SHIFT_W-1:0] lz_q, lz_d;
    logic               zero_q, zero_d;
    logic               resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [8:0]         resp_recip_q, resp_recip_d;
    logic [SHIFT_W-1:0] resp_shift_q, resp_shift_d;
    logic               resp_err_q, resp_err_d;

    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic [SUM_W-1:0]   grant_sum;
    logic [8:0]         lut_recip;

    recip_lut u_lut (
        .m_i     (shreg_q[SUM_W-1 -: 7]),
        .recip_o (lut_recip)
    );

    // Search pointer+1 .. pointer+N_REQ; iterating downward lets the nearest hit win.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req_valid[(int'(ptr_q) + k) % N_REQ]) begin
                grant_valid = 1'b1;
                grant_id    = ID_W'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    assign grant_sum = req_sum[grant_id*SUM_W +: SUM_W];

`ifdef RECIP_SCHED_FAST_NORM_EN
    logic [SHIFT_W-1:0] lz_fast;

    always_comb begin
        lz_fast = '0;
        for (int b = 0; b < SUM_W; b++) begin
            if (shreg_q[b]) begin
                lz_fast = SHIFT_W'(SUM_W - 1 - b);
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        shreg_d      = shreg_q;
        lz_d         = lz_q;
        zero_d       = zero_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_recip_d = resp_recip_q;
        resp_shift_d = resp_shift_q;
        resp_err_d   = resp_err_q;
        req_ready    = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    req_ready = N_REQ'(1) << grant_id;
                    ptr_d     = grant_id;
                    id_d      = grant_id;
                    shreg_d   = grant_sum;
                    zero_d    = (grant_sum == '0);
                    lz_d      = '0;
                    state_d   = S_NORM;
                end
            end
            S_NORM: begin
`ifdef RECIP_SCHED_FAST_NORM_EN
                if (!zero_q) begin
                    shreg_d = shreg_q << lz_fast;
                    lz_d    = lz_fast;
                end
                state_d = S_LOOKUP;
`else
                if (zero_q || shreg_q[SUM_W-1]) begin
                    state_d = S_LOOKUP;
                end else begin
                    shreg_d = shreg_q << 1;
                    lz_d    = lz_q + 1'b1;
                end
`endif
            end
            S_LOOKUP: begin
                resp_id_d    = id_q;
                resp_err_d   = zero_q;
                resp_recip_d = zero_q ? 9'h1FF : lut_recip;
                resp_shift_d = zero_q ? '0 : SHIFT_W'(SUM_W) - lz_q;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= ID_W'(N_REQ - 1);
            id_q         <= '0;
            shreg_q      <= '0;
            lz_q         <= '0;
            zero_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_recip_q <= '0;
            resp_shift_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            shreg_q      <= shreg_d;
            lz_q         <= lz_d;
            zero_q       <= zero_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_recip_q <= resp_recip_d;
            resp_shift_q <= resp_shift_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_recip = resp_recip_q;
    assign resp_shift = resp_shift_q;
    assign resp_err   = resp_err_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_recip_sched.sv
// tb/tb_recip_sched.sv - scoreboard bench for recip_sched with directed vectors
module tb_recip_sched;
    localparam int N  = 4;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*SW-1:0] req_sum;
    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_id;
    logic [8:0]    resp_recip;
    logic [4:0]    resp_shift;
    logic          resp_err;
    logic          busy;

    recip_sched #(.N_REQ(N), .SUM_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sum    (req_sum),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_recip (resp_recip),
        .resp_shift (resp_shift),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [8:0] recip;
        logic [4:0] shift;
        logic       err;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   gq[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_grants = 0;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int lat_of(input int lz);
`ifdef RECIP_SCHED_FAST_NORM_EN
        return 3;
`else
        return lz + 3;
`endif
    endfunction

    task automatic push(input int id, input int recip, input int shift, input int err, input int lat);
        exp_t e;
        e.id = 2'(id); e.recip = 9'(recip); e.shift = 5'(shift); e.err = 1'(err); e.lat = lat;
        sb.push_back(e);
    endtask

    // Monitor: grant bookkeeping and response comparison against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            gq.delete();
            prev_valid = 1'b0;
        end else begin
            if (resp_valid && !prev_valid) rise_cyc = cyc;
            if (req_ready != '0) begin
                check("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
                check("grant_overlaps_resp", 32'(resp_valid), 32'd0);
                gq.push_back(cyc);
                n_grants++;
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp_id", 32'(resp_id), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_id", 32'(resp_id), 32'(e.id));
                    check("resp_recip", 32'(resp_recip), 32'(e.recip));
                    check("resp_shift", 32'(resp_shift), 32'(e.shift));
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    if (gq.size() != 0) check("latency", 32'(rise_cyc - gq.pop_front()), 32'(e.lat));
                    else check("latency_no_grant", 32'd0, 32'd1);
                end
            end
            prev_valid = resp_valid;
        end
    end

    task automatic wait_grant(input int idx);
        int t = 0;
        while (t < 200) begin
            @(negedge clk);
            if (req_ready[idx]) break;
            t++;
        end
        if (t >= 200) check("grant_timeout", 32'(idx), 32'hFFFF_FFFF);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic issue(input int idx, input logic [15:0] sum);
        @(posedge clk); #1;
        req_sum[idx*SW +: SW] = sum;
        req_valid[idx] = 1'b1;
        wait_grant(idx);
    endtask

    task automatic drain();
        int t = 0;
        while (t < 300 && (sb.size() != 0 || busy)) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        logic [16:0] snap;
        int t;
        int g0;
        rst = 1'b1; req_valid = '0; req_sum = '0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_fields", {15'd0, resp_id, resp_recip, resp_shift, resp_err}, 32'd0);

        push(0, 'h1FF, 16, 0, 3);           issue(0, 16'h8000); drain();
        push(2, 'h155, 2, 0, lat_of(14));   issue(2, 16'h0003); drain();
        push(1, 'h1FF, 0, 1, 3);            issue(1, 16'h0000); drain();

        do_reset();
        push(0, 'h1C7, 13, 0, lat_of(3));
        push(1, 'h102, 8, 0, lat_of(8));
        push(2, 'h1FF, 15, 0, lat_of(1));
        push(3, 'h102, 16, 0, 3);
        push(0, 'h1C7, 13, 0, lat_of(3));
        @(posedge clk); #1;
        req_sum = {16'hFFFF, 16'h4000, 16'h00FF, 16'h1234};
        g0 = n_grants;
        req_valid = 4'hF;
        t = 0;
        while (t < 500 && n_grants < g0 + 5) begin @(negedge clk); t++; end
        if (t >= 500) check("fair_timeout", 32'(n_grants - g0), 32'd5);
        @(posedge clk); #1 req_valid = '0;
        drain();

        resp_ready = 1'b0;
        push(3, 'h102, 8, 0, lat_of(8));
        issue(3, 16'h00FF);
        t = 0;
        while (t < 200 && !resp_valid) begin @(negedge clk); t++; end
        if (t >= 200) check("stall_resp_timeout", 32'(resp_valid), 32'd1);
        snap = {resp_id, resp_recip, resp_shift, resp_err};
        @(posedge clk); #1;
        push(0, 'h1FF, 16, 0, 3);
        req_sum[0 +: SW] = 16'h8000;
        req_valid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_stable", 32'({resp_id, resp_recip, resp_shift, resp_err}), 32'(snap));
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        check("hs_cycle_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("post_hs_resp_valid", 32'(resp_valid), 32'd0);
        check("post_hs_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        drain();

        issue(2, 16'h0001);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_norm_rst_busy", 32'(busy), 32'd0);
        check("mid_norm_rst_valid", 32'(resp_valid), 32'd0);
        push(0, 'h155, 10, 0, lat_of(6));
        push(3, 'h102, 16, 0, 3);
        @(posedge clk); #1;
        req_sum[0 +: SW] = 16'h0300;
        req_sum[3*SW +: SW] = 16'hFFFF;
        req_valid = 4'b1001;
        wait_grant(0);
        wait_grant(3);
        drain();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
